// File: rtl/dcache_line_fill.sv
// Line-refill controller: on a cacheable miss, reads the aligned 4-word line from BRAM one word per cycle and installs it.
// Latency: miss cycle + 4 issue cycles + 1 drain cycle + 1 update cycle = 7 stalled cycles; UPDATE pulses 6 cycles after the miss.
// Backpressure: none accepted; STALL holds the pipeline for the whole refill, and MISS/ADDR are ignored while busy.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   MISS, ADDR          cache miss request (level) and its byte address
//   MEM_RDEN, MEM_ADDR  synchronous BRAM read port (word-aligned address, 0 when idle)
//   MEM_RDATA           BRAM read data, valid the edge after the read was issued
//   W0..W3              assembled line words, Wi = word at line base + 4*i
//   UPDATE              one-cycle pulse: W0..W3 complete, install the line
//   STALL               pipeline stall, combinational so it covers the miss cycle
//
// Optional feature: define DCACHE_CRITICAL_WORD_FIRST_EN to fetch the missed word
// first and wrap modulo 4; words still land in their true slots.

module dcache_line_fill #(
  parameter int unsigned LINE_WORDS = 4,
  parameter logic [31:0] IO_BASE    = 32'h0001_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MISS,
  input  logic [31:0] ADDR,
  output logic        MEM_RDEN,
  output logic [31:0] MEM_ADDR,
  input  logic [31:0] MEM_RDATA,
  output logic [31:0] W0,
  output logic [31:0] W1,
  output logic [31:0] W2,
  output logic [31:0] W3,
  output logic        UPDATE,
  output logic        STALL
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    UPD   = 2'd3
  } state_t;

  localparam logic [1:0] LAST_ISSUE = 2'(LINE_WORDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [27:0] base_q;      // line address bits [31:4]; never change during a fill
  logic [1:0]  issue_cnt;
  logic [1:0]  slot;        // line slot of the word being issued this cycle
  logic        rvalid;      // MEM_RDEN delayed one cycle: MEM_RDATA is valid now
  logic [1:0]  rslot;       // slot that the returning word belongs to
  logic [31:0] w_q [4];
  logic        cacheable_miss;
  logic        accept;

  // MMIO misses are never filled and must not stall the pipeline.
  assign cacheable_miss = MISS & (ADDR < IO_BASE);
  assign accept         = (state == IDLE) & cacheable_miss;

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  logic [1:0] start_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      start_q <= 2'd0;
    end else if (accept) begin
      start_q <= ADDR[3:2];
    end
  end

  // 2-bit sum wraps 3->0, giving the critical-word-first order.
  assign slot = start_q + issue_cnt;
`else
  assign slot = issue_cnt;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs.
  always_comb begin
    state_nxt = state;
    MEM_RDEN  = 1'b0;
    MEM_ADDR  = 32'd0;
    UPDATE    = 1'b0;
    STALL     = 1'b0;
    case (state)
      IDLE: begin
        if (cacheable_miss) begin
          STALL     = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        STALL    = 1'b1;
        MEM_RDEN = 1'b1;
        // Offset is at most 12 bytes, so concatenation replaces an adder.
        MEM_ADDR = {base_q, slot, 2'b00};
        if (issue_cnt == LAST_ISSUE) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Last read's data is captured at the end of this cycle.
        STALL     = 1'b1;
        state_nxt = UPD;
      end
      UPD: begin
        STALL     = 1'b1;
        UPDATE    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch and issue counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      base_q    <= 28'd0;
      issue_cnt <= 2'd0;
    end else if (accept) begin
      base_q    <= ADDR[31:4];
      issue_cnt <= 2'd0;
    end else if (state == FILL) begin
      issue_cnt <= issue_cnt + 2'd1;
    end
  end

  // Read-return tracking: the slot travels alongside the one-cycle BRAM latency.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rvalid <= 1'b0;
      rslot  <= 2'd0;
    end else begin
      rvalid <= MEM_RDEN;
      rslot  <= slot;
    end
  end

  // Line assembly. Clearing rvalid on reset guarantees no stray capture
  // from a read issued just before a mid-fill reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        w_q[i] <= 32'd0;
      end
    end else if (rvalid) begin
      w_q[rslot] <= MEM_RDATA;
    end
  end

  assign W0 = w_q[0];
  assign W1 = w_q[1];
  assign W2 = w_q[2];
  assign W3 = w_q[3];

endmodule

// File: tb/tb_dcache_line_fill.sv
module tb_dcache_line_fill;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        CLK;
  logic        RST;
  logic        MISS;
  logic [31:0] ADDR;
  logic        MEM_RDEN;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_RDATA;
  logic [31:0] W0, W1, W2, W3;
  logic        UPDATE;
  logic        STALL;

  int checks = 0;
  int errors = 0;

  logic [31:0]  exp_addr [$];
  logic [127:0] exp_line [$];

  dcache_line_fill dut (
    .CLK       (CLK),
    .RST       (RST),
    .MISS      (MISS),
    .ADDR      (ADDR),
    .MEM_RDEN  (MEM_RDEN),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_RDATA (MEM_RDATA),
    .W0        (W0),
    .W1        (W1),
    .W2        (W2),
    .W3        (W3),
    .UPDATE    (UPDATE),
    .STALL     (STALL)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Synchronous BRAM model: data for a read appears after the next rising edge.
  always @(posedge CLK) begin
    if (MEM_RDEN) MEM_RDATA <= MEM_ADDR ^ KEY;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read or a line.
  always @(negedge CLK) begin
    if (MEM_RDEN) begin
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got read of %h expected no read", MEM_ADDR);
      end else begin
        chk("rd_addr", {96'd0, MEM_ADDR}, {96'd0, exp_addr.pop_front()});
      end
    end else begin
      chk("addr_zero_when_idle", {96'd0, MEM_ADDR}, 128'd0);
    end
    if (UPDATE) begin
      if (exp_line.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL upd_unexpected: got UPDATE expected none");
      end else begin
        chk("line_words", {W3, W2, W1, W0}, exp_line.pop_front());
      end
    end
  end

  // Runs one fill from its miss cycle (cycle 0) through UPD (cycle 6).
  // ADDR is switched to alt during FILL; MISS is left at keep after UPD.
  task automatic fill(input logic [31:0] a, input logic [31:0] alt, input logic keep);
    logic [31:0] base;
    logic [1:0]  s;
    base = {a[31:4], 4'b0000};
    for (int n = 0; n < 4; n++) begin
`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
      s = a[3:2] + 2'(n);
`else
      s = 2'(n);
`endif
      exp_addr.push_back(base + {28'd0, s, 2'b00});
    end
    exp_line.push_back({(base + 32'd12) ^ KEY, (base + 32'd8) ^ KEY,
                        (base + 32'd4) ^ KEY, base ^ KEY});
    MISS = 1'b1;
    ADDR = a;
    #1;
    chk("stall_c0", {127'd0, STALL}, 128'd1);
    chk("rden_c0", {127'd0, MEM_RDEN}, 128'd0);
    chk("upd_c0", {127'd0, UPDATE}, 128'd0);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) ADDR = alt;
      chk("stall_busy", {127'd0, STALL}, 128'd1);
      chk("rden_window", {127'd0, MEM_RDEN}, {127'd0, (c >= 1 && c <= 4)});
      chk("upd_cycle6", {127'd0, UPDATE}, {127'd0, (c == 6)});
      if (c == 6) MISS = keep;
    end
  endtask

  task automatic chk_idle();
    chk("idle_stall", {127'd0, STALL}, 128'd0);
    chk("idle_upd", {127'd0, UPDATE}, 128'd0);
    chk("idle_rden", {127'd0, MEM_RDEN}, 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST  = 1'b1;
    MISS = 1'b0;
    ADDR = 32'd0;
    repeat (2) step();
    chk("rst_rden", {127'd0, MEM_RDEN}, 128'd0);
    chk("rst_addr", {96'd0, MEM_ADDR}, 128'd0);
    chk("rst_upd", {127'd0, UPDATE}, 128'd0);
    chk("rst_stall", {127'd0, STALL}, 128'd0);
    chk("rst_words", {W3, W2, W1, W0}, 128'd0);
    RST = 1'b0;
    step();

    // Basic fill.
    fill(32'h0000_1234, 32'h0000_1234, 1'b0);
    step();
    chk_idle();
    // Line stays stable after UPD.
    chk("words_hold", {W3, W2, W1, W0}, {32'hA5A5_123C, 32'hA5A5_1238, 32'hA5A5_1234, 32'hA5A5_1230});

    // Unaligned miss in the middle of the line.
    fill(32'h0000_0048, 32'h0000_0048, 1'b0);
    step();
    chk_idle();

    // MMIO miss: ignored entirely.
    MISS = 1'b1;
    ADDR = 32'h0001_0000;
    #1;
    chk("mmio_stall", {127'd0, STALL}, 128'd0);
    repeat (4) begin
      step();
      chk_idle();
    end
    MISS = 1'b0;
    step();

    // ADDR changes while busy must not move the line.
    fill(32'h0000_1000, 32'h0000_2000, 1'b0);
    step();
    chk_idle();

    // Reset in cycle 3 of a fill: only the reads of cycles 1-2 happen.
    exp_addr.push_back(32'h0000_3000);
    exp_addr.push_back(32'h0000_3004);
    MISS = 1'b1;
    ADDR = 32'h0000_3000;
    #1;
    chk("rfill_stall_c0", {127'd0, STALL}, 128'd1);
    repeat (3) step();
    RST  = 1'b1;
    MISS = 1'b0;
    #1;
    chk("mid_rst_rden", {127'd0, MEM_RDEN}, 128'd0);
    chk("mid_rst_stall", {127'd0, STALL}, 128'd0);
    chk("mid_rst_upd", {127'd0, UPDATE}, 128'd0);
    chk("mid_rst_addr", {96'd0, MEM_ADDR}, 128'd0);
    chk("mid_rst_words", {W3, W2, W1, W0}, 128'd0);
    repeat (2) begin
      step();
      chk("rst_hold_upd", {127'd0, UPDATE}, 128'd0);
    end
    RST = 1'b0;
    step();
    chk_idle();
    fill(32'h0000_3008, 32'h0000_3008, 1'b0);
    step();
    chk_idle();

    // Back-to-back: MISS held through UPD restarts at cycle 7, UPDATE again at 13.
    fill(32'h0000_5004, 32'h0000_5004, 1'b1);
    step();
    fill(32'h0000_5004, 32'h0000_5004, 1'b0);
    step();
    chk_idle();

    repeat (3) step();
    chk("addr_queue_drained", {96'd0, 32'(exp_addr.size())}, 128'd0);
    chk("line_queue_drained", {96'd0, 32'(exp_line.size())}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
